stim_pattern_gen: RTL and testbench
===================================

// Module: stim_pattern_gen
// PURPOSE
// Programmable stimulus source sitting directly upstream of the property checkers.
// Drives a one-cycle start marker (temp_out) and a square wave (a_out) with programmable half-period.
// Runs for a bounded number of clock edges, then signals done so the bench can end simulation.
// Replaces free-running "always #N" stimulus with a clocked, resettable, repeatable source.
// PARAMETERS
// CNT_W     8   width of half_period, run_len, cyc_cnt and the internal phase counter
// DEF_HALF  2   half-period used when half_period==0 at start (2 edges = toggle every 2 clk)
// PORTS
// clk          in   1      single clock; all state updates on posedge
// rst_n        in   1      asynchronous, active-low reset
// start        in   1      request a run; sampled only in IDLE or DONE
// half_period  in   CNT_W  a_out half-period in clk cycles; latched at accepted start
// run_len      in   CNT_W  number of RUN cycles; latched at accepted start
// temp_out     out  1      start marker: high exactly one cycle (PULSE state)
// a_out        out  1      square wave, low at start of RUN
// busy         out  1      high in PULSE and RUN
// done         out  1      high in DONE, held until next accepted start or reset
// cyc_cnt      out  CNT_W  RUN cycles completed in current run
// BEHAVIOUR
// - Reset (async, rst_n=0): state=IDLE; temp_out=0, a_out=0, busy=0, done=0, cyc_cnt=0, phase=0.
// - All outputs registered; no combinational input-to-output path.
// - FSM states IDLE, PULSE, RUN, DONE:
//   IDLE/DONE + start=1 @edge -> PULSE: latch hp=(half_period==0?DEF_HALF:half_period), rl=run_len;
//     temp_out<=1, busy<=1, done<=0, a_out<=0, cyc_cnt<=0, phase<=0. Latency start->temp_out: 1 edge.
//   PULSE @next edge -> RUN (rl!=0) or DONE (rl==0); temp_out<=0 unconditionally.
//   RUN each edge: cyc_cnt<=cyc_cnt+1; phase<=phase+1; when phase==hp-1: a_out<=~a_out, phase<=0.
//   RUN: edge where cyc_cnt==rl-1 -> DONE (cyc_cnt ends ==rl; the toggle rule still applies on this edge).
//   DONE: busy<=0, done<=1, a_out<=0; cyc_cnt holds final value.
// - start while PULSE or RUN: ignored, no restart, no error.
// - start held high continuously: restarts every time DONE is reached (DONE lasts 1 cycle then PULSE).
// - half_period/run_len changes mid-run have no effect (latched copies only).
// - Counters never wrap: rl<=2^CNT_W-1 bounds cyc_cnt; phase bounded by hp-1.
// - rst_n asserted mid-run: immediate return to IDLE reset values; run not resumed on release.
// - First accepted start after reset behaves identically to a start from DONE.
// STRUCTURE
// - stim_pkg: typedef enum logic [1:0] {IDLE, PULSE, RUN, DONE} stim_state_t; localparam CNT_W default.
// - One sub-module natural: half_period_toggler (phase counter + a_out toggle; inputs en, clr, hp).
// - Top holds FSM, latched hp/rl, cyc_cnt, temp_out/busy/done registers.
// TESTING
// - Reset then idle 5 cycles, start never asserted -> all outputs stay 0, state IDLE.
// - start=1 one cycle, half_period=2, run_len=10 -> temp_out high 1 cycle after start edge;
//   a_out 0,0,1,1,0,0,1,1,0,0 over RUN; done=1 after 10 RUN cycles, cyc_cnt=10.
// - half_period=0, run_len=6 -> DEF_HALF=2 used: a_out 0,0,1,1,0,0; done after 6 cycles.
// - run_len=0 -> PULSE then DONE directly; a_out never toggles, cyc_cnt=0, done=1.
// - start pulsed again at RUN cycle 3 (hp=1, rl=8) -> ignored; a_out toggles every cycle, done after 8.
// - rst_n=0 at RUN cycle 4 -> outputs 0 same delta (async), IDLE after release; new start runs cleanly.
// - Bench asserts: $rose(temp_out) |-> a_out==0; busy |-> !done; temp_out lasts exactly 1 cycle.

Source files
------------

// File: rtl/stim_pattern_gen_pkg.sv
// stim_pattern_gen_pkg
//   Shared definitions for the stimulus pattern generator: default counter
//   width, default half-period and the FSM state type.
package stim_pattern_gen_pkg;

  localparam int CNT_W_DEF    = 8;
  localparam int DEF_HALF_DEF = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } stim_state_t;

endpackage

// File: rtl/stim_pattern_gen_half_period_toggler.sv
// half_period_toggler
//   Phase counter plus square-wave register. While en is high the phase
//   counter advances every clock; when it reaches hp-1 the output flips and
//   the phase restarts at 0. clr forces phase and output back to 0 and has
//   priority over en.
// Ports:
//   clk    in   1      clock, posedge
//   rst_n  in   1      asynchronous active-low reset
//   en     in   1      advance phase / allow toggling
//   clr    in   1      synchronous clear of phase and a_out
//   hp     in   CNT_W  half-period in clock cycles (must be non-zero)
//   a_out  out  1      registered square wave
module half_period_toggler
  import stim_pattern_gen_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic [CNT_W-1:0] hp,
  output logic             a_out
);

  logic [CNT_W-1:0] phase_reg, phase_next;
  logic             a_reg, a_next;

  always_comb begin
    phase_next = phase_reg;
    a_next     = a_reg;
    if (clr) begin
      phase_next = '0;
      a_next     = 1'b0;
    end else if (en) begin
      // Wrap at hp-1 so the phase never exceeds the half-period.
      if (phase_reg == hp - CNT_W'(1)) begin
        phase_next = '0;
        a_next     = ~a_reg;
      end else begin
        phase_next = phase_reg + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_reg <= '0;
      a_reg     <= 1'b0;
    end else begin
      phase_reg <= phase_next;
      a_reg     <= a_next;
    end
  end

  assign a_out = a_reg;

endmodule

// File: rtl/stim_pattern_gen.sv
// stim_pattern_gen
//   Clocked, resettable stimulus source. An accepted start emits a one-cycle
//   marker (temp_out), then runs a square wave (a_out) with a programmable
//   half-period for run_len cycles, then raises done until the next start.
// Ports:
//   clk          in   1      clock, posedge
//   rst_n        in   1      asynchronous active-low reset
//   start        in   1      run request, honoured only in IDLE or DONE
//   half_period  in   CNT_W  a_out half-period (0 selects DEF_HALF), latched
//   run_len      in   CNT_W  number of RUN cycles, latched
//   temp_out     out  1      start marker, high for the single PULSE cycle
//   a_out        out  1      square wave, low at the start of RUN
//   busy         out  1      high in PULSE and RUN
//   done         out  1      high in DONE
//   cyc_cnt      out  CNT_W  RUN cycles completed in the current run
module stim_pattern_gen
  import stim_pattern_gen_pkg::*;
#(
  parameter int CNT_W    = CNT_W_DEF,
  parameter int DEF_HALF = DEF_HALF_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] half_period,
  input  logic [CNT_W-1:0] run_len,
  output logic             temp_out,
  output logic             a_out,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] cyc_cnt
);

  stim_state_t      state_reg, state_next;
  logic [CNT_W-1:0] hp_reg, hp_next;
  logic [CNT_W-1:0] rl_reg, rl_next;
  logic [CNT_W-1:0] cyc_cnt_reg, cyc_cnt_next;
  logic             temp_out_reg, temp_out_next;
  logic             busy_reg, busy_next;
  logic             done_reg, done_next;
  logic             accept;

  assign accept = start && ((state_reg == IDLE) || (state_reg == DONE));

  always_comb begin
    state_next    = state_reg;
    hp_next       = hp_reg;
    rl_next       = rl_reg;
    cyc_cnt_next  = cyc_cnt_reg;
    temp_out_next = temp_out_reg;
    busy_next     = busy_reg;
    done_next     = done_reg;

    case (state_reg)
      PULSE: begin
        temp_out_next = 1'b0;
        if (rl_reg == '0) begin
          state_next = DONE;
          busy_next  = 1'b0;
          done_next  = 1'b1;
        end else begin
          state_next = RUN;
        end
      end
      RUN: begin
        cyc_cnt_next = cyc_cnt_reg + CNT_W'(1);
        if (cyc_cnt_reg == rl_reg - CNT_W'(1)) begin
          state_next = DONE;
          busy_next  = 1'b0;
          done_next  = 1'b1;
        end
      end
      default: ;  // IDLE and DONE wait for start below
    endcase

    if (accept) begin
      state_next    = PULSE;
      hp_next       = (half_period == '0) ? CNT_W'(DEF_HALF) : half_period;
      rl_next       = run_len;
      cyc_cnt_next  = '0;
      temp_out_next = 1'b1;
      busy_next     = 1'b1;
      done_next     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      hp_reg       <= '0;
      rl_reg       <= '0;
      cyc_cnt_reg  <= '0;
      temp_out_reg <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      hp_reg       <= hp_next;
      rl_reg       <= rl_next;
      cyc_cnt_reg  <= cyc_cnt_next;
      temp_out_reg <= temp_out_next;
      busy_reg     <= busy_next;
      done_reg     <= done_next;
    end
  end

  // Outside RUN the wave is held cleared, so every run starts low with
  // phase 0; the final RUN edge may still toggle before DONE clears it.
  half_period_toggler #(
    .CNT_W (CNT_W)
  ) u_toggler (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (state_reg == RUN),
    .clr   (state_reg != RUN),
    .hp    (hp_reg),
    .a_out (a_out)
  );

  assign temp_out = temp_out_reg;
  assign busy     = busy_reg;
  assign done     = done_reg;
  assign cyc_cnt  = cyc_cnt_reg;

endmodule

// File: tb/tb_stim_pattern_gen.sv
module tb_stim_pattern_gen;

  localparam int DEF_HALF = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] half_period = '0;
  logic [7:0] run_len = '0;
  logic       temp_out, a_out, busy, done;
  logic [7:0] cyc_cnt;

  stim_pattern_gen #(.CNT_W(8), .DEF_HALF(DEF_HALF)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .half_period (half_period),
    .run_len     (run_len),
    .temp_out    (temp_out),
    .a_out       (a_out),
    .busy        (busy),
    .done        (done),
    .cyc_cnt     (cyc_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int txn_count = 0;

  // Expected run: effective half-period and run length.
  typedef struct {
    int hp;
    int rl;
  } exp_t;
  exp_t sb_q[$];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  bit   mon_active = 1'b0;
  int   mon_k = 0;
  int   mon_fail_base = 0;
  bit   prev_temp = 1'b0;
  exp_t cur;

  always @(negedge clk) begin
    if (!rst_n) begin
      if (mon_active)
        $display("TXN %0d aborted by reset after %0d RUN cycles", txn_count, mon_k);
      mon_active = 1'b0;
      prev_temp  = 1'b0;
    end else begin
      if (temp_out) begin
        check("temp_out_single_cycle", int'(prev_temp), 0);
        check("pulse_while_active", int'(mon_active), 0);
        if (sb_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_pulse actual=pulse required=no_pulse t=%0t", $time);
          mon_active = 1'b0;
        end else begin
          cur           = sb_q.pop_front();
          mon_active    = 1'b1;
          mon_k         = 0;
          mon_fail_base = failures;
          txn_count++;
          check("pulse_a_out", int'(a_out), 0);
          check("pulse_done", int'(done), 0);
          check("pulse_busy", int'(busy), 1);
        end
      end else if (mon_active) begin
        if (busy) begin
          // Reference wave: low for hp cycles, high for hp cycles, ...
          check("run_a_out", int'(a_out), (mon_k / cur.hp) % 2);
          check("run_cyc_cnt", int'(cyc_cnt), mon_k);
          check("run_done_low", int'(done), 0);
          mon_k++;
          if (mon_k > cur.rl) begin
            checks++;
            failures++;
            $display("FAIL run_too_long actual=%0d required<=%0d", mon_k, cur.rl);
            mon_active = 1'b0;
          end
        end else if (done) begin
          check("txn_run_cycles", mon_k, cur.rl);
          check("txn_cyc_cnt", int'(cyc_cnt), cur.rl);
          $display("TXN %0d hp=%0d rl=%0d run_cycles=%0d cyc_cnt=%0d errors=%0d",
                   txn_count, cur.hp, cur.rl, mon_k, cyc_cnt, failures - mon_fail_base);
          mon_active = 1'b0;
        end else begin
          checks++;
          failures++;
          $display("FAIL run_dropped actual=busy0_done0 required=busy_or_done");
          mon_active = 1'b0;
        end
      end
      prev_temp = temp_out;
    end
  end

  // ---------------- protocol assertions ----------------
  a_rose_low: assert property (@(posedge clk) disable iff (!rst_n)
                               $rose(temp_out) |-> (a_out == 1'b0))
    else begin failures++; $display("FAIL assert_rose_temp_a_out actual=1 required=0"); end
  a_busy_done: assert property (@(posedge clk) disable iff (!rst_n) busy |-> !done)
    else begin failures++; $display("FAIL assert_busy_done actual=both required=exclusive"); end
  a_temp_one: assert property (@(posedge clk) disable iff (!rst_n) temp_out |=> !temp_out)
    else begin failures++; $display("FAIL assert_temp_width actual=2 required=1"); end

  // ---------------- stimulus ----------------
  task automatic check_idle_zero(input string name);
    check({name, "_temp_out"}, int'(temp_out), 0);
    check({name, "_a_out"}, int'(a_out), 0);
    check({name, "_busy"}, int'(busy), 0);
    check({name, "_done"}, int'(done), 0);
    check({name, "_cyc_cnt"}, int'(cyc_cnt), 0);
  endtask

  task automatic issue_start(input int hp, input int rl);
    exp_t e;
    @(negedge clk);
    start       = 1'b1;
    half_period = 8'(hp);
    run_len     = 8'(rl);
    e.hp = (hp == 0) ? DEF_HALF : hp;
    e.rl = rl;
    sb_q.push_back(e);
    @(negedge clk);
    start = 1'b0;
    // Scramble the inputs mid-run; only the latched copies may matter.
    half_period = 8'($urandom_range(0, 255));
    run_len     = 8'($urandom_range(0, 255));
    check("latency_temp_out", int'(temp_out), 1);
    check("latency_busy", int'(busy), 1);
  endtask

  task automatic wait_done(input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL done_timeout actual=done_low required=done_high budget=%0d", budget);
    end
  endtask

  task automatic post_done(input int rl);
    check("done_cyc_cnt", int'(cyc_cnt), rl);
    check("done_busy", int'(busy), 0);
    @(negedge clk);
    check("done_held", int'(done), 1);
    check("done_a_out_cleared", int'(a_out), 0);
    check("done_cyc_hold", int'(cyc_cnt), rl);
  endtask

  task automatic run_one(input int hp, input int rl);
    issue_start(hp, rl);
    wait_done(rl + 8);
    post_done(rl);
  endtask

  initial begin
    int ndone;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Idle without start: everything stays at reset values.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_idle_zero("idle");
    end

    run_one(2, 10);
    run_one(0, 6);
    run_one(3, 0);

    // Second start during RUN cycle 3 must be ignored.
    issue_start(1, 8);
    repeat (4) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(16);
    post_done(8);

    // Asynchronous reset in RUN cycle 4.
    issue_start(2, 10);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_idle_zero("async_reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check_idle_zero("no_resume");
    end
    run_one(2, 4);

    // start held high: three back-to-back runs.
    @(negedge clk);
    start       = 1'b1;
    half_period = 8'd3;
    run_len     = 8'd4;
    for (int i = 0; i < 3; i++) begin
      exp_t e;
      e.hp = 3;
      e.rl = 4;
      sb_q.push_back(e);
    end
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) ndone++;
      if (ndone == 3) break;
    end
    start = 1'b0;
    check("continuous_done_count", ndone, 3);
    post_done(4);

    // Randomized runs.
    for (int n = 0; n < 20; n++) begin
      run_one(int'($urandom_range(0, 6)), int'($urandom_range(0, 24)));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    check("scoreboard_empty", sb_q.size(), 0);
    check("monitor_idle", int'(mon_active), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
